// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int CLKS_PER_BIT_MIN = 4;
  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to 1 so an idle UART/CTS line
// reads as inactive.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with valid/ready output and framing/parity/overrun status.
// Optional parity bit is compiled in with UART_RX_PARITY_EN.
//   state  | meaning
//   IDLE   | line high, waiting for a start edge
//   START  | wait to mid start bit, reject glitches
//   DATA   | sample DATA_BITS data bits, LSB first
//   PARITY | sample parity bit (UART_RX_PARITY_EN only)
//   STOP   | sample STOP_BITS stop bits, then complete the word
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TGT  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] BIT_TGT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_cpb
    $error("uart_rx_core: CLKS_PER_BIT too small");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_db
    $error("uart_rx_core: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_sb
    $error("uart_rx_core: STOP_BITS out of range");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_rx_core: PARITY_ODD must be 0 or 1");
  end

  logic                 w_rx_s;
  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_fe;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frm;
  logic                 r_ovr;
  logic                 w_sample;
  logic                 w_done;
  logic                 w_load;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_i),
    .o_q   (w_rx_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == HALF_TGT) begin
          w_sample    = 1'b1;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_TGT) begin
          w_sample = 1'b1;
          if (r_bit == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == BIT_TGT) begin
          w_sample    = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == BIT_TGT) begin
          w_sample = 1'b1;
          if (r_bit == STOP_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_fe    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
        r_bit <= '0;
      end else if (w_sample) begin
        r_cnt <= '0;
        r_bit <= r_bit + 4'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ST_DATA && w_sample) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      if (r_state == ST_IDLE && !w_rx_s) r_fe <= 1'b0;
      else if (r_state == ST_STOP && w_sample && !w_rx_s) r_fe <= 1'b1;
    end
  end

  // A finished word may load only into an empty slot or one being drained this cycle.
  assign w_load = w_done && (!r_valid || rx_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_frm   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_done && r_valid && !rx_ready_i;
      if (w_load) begin
        r_data  <= r_shift;
        r_frm   <= r_fe | ~w_rx_s;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_pe;
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pe  <= 1'b0;
      r_par <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && !w_rx_s) r_pe <= 1'b0;
      else if (r_state == ST_PARITY && w_sample) r_pe <= (^r_shift) ^ PARITY_ODD[0] ^ w_rx_s;
      if (w_load) r_par <= r_pe;
    end
  end

  assign parity_err_o = r_par;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_frm;
  assign overrun_o   = r_ovr;

endmodule
